// File: rtl/buyruk_alici_pkg.sv
// rtl/buyruk_alici_pkg.sv - shared widths, levels and receiver state encodings
package buyruk_alici_pkg;
  localparam int BUYRUK_BIT   = 32;
  localparam int BB_ADRES_BIT = 32;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  typedef enum logic [1:0] {
    ALICI_AKIS  = 2'd0,
    ALICI_ISTEK = 2'd1,
    ALICI_ATLA  = 2'd2
  } alici_durum_t;
endpackage

// File: rtl/buyruk_fifo.sv
// rtl/buyruk_fifo.sv - instruction/PC FIFO with flush and occupancy count
module buyruk_fifo #(
  parameter int DERINLIK = 4,
  parameter int GENISLIK = 64
) (
  input  logic                               clk_g,
  input  logic                               rst_g,
  input  logic                               push,
  input  logic                               pop,
  input  logic                               flush,
  input  logic [GENISLIK-1:0]                yaz_veri,
  output logic [GENISLIK-1:0]                oku_veri,
  output logic [$clog2(DERINLIK+1)-1:0]      count
);
  localparam int PW = $clog2(DERINLIK);

  logic [GENISLIK-1:0] bellek [DERINLIK];
  logic [PW-1:0]       yaz_ptr;
  logic [PW-1:0]       oku_ptr;

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      count   <= '0;
    end else if (flush) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      count   <= '0;
    end else begin
      if (push) yaz_ptr <= yaz_ptr + 1'b1;
      if (pop)  oku_ptr <= oku_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage holds no reset: contents are only visible once count says so.
  always_ff @(posedge clk_g) begin
    if (push && !flush) bellek[yaz_ptr] <= yaz_veri;
  end

  assign oku_veri = bellek[oku_ptr];
endmodule

// File: rtl/buyruk_alici.sv
// rtl/buyruk_alici.sv - GC-side instruction receive buffer with redirect handling
module buyruk_alici
  import buyruk_alici_pkg::*;
#(
  parameter int DERINLIK = 4
) (
  input  logic                    clk_g,
  input  logic                    rst_g,
  input  logic                    bb_buy_gecerli_g,
  input  logic [BUYRUK_BIT-1:0]   bb_buy_g,
  input  logic [BB_ADRES_BIT-1:0] bb_buy_ps_g,
  output logic                    gc_hazir_c,
  output logic                    bb_buy_istek_c,
  output logic [BB_ADRES_BIT-1:0] bb_buy_istek_adres_c,
  input  logic                    yonlendir_g,
  input  logic [BB_ADRES_BIT-1:0] yonlendir_adres_g,
  input  logic                    coz_hazir_g,
  output logic                    coz_gecerli_c,
  output logic [BUYRUK_BIT-1:0]   coz_buyruk_c,
  output logic [BB_ADRES_BIT-1:0] coz_ps_c
);
  localparam int SW = $clog2(DERINLIK+1);

  alici_durum_t                durum;
  logic [BB_ADRES_BIT-1:0]     istek_adres_r;
  logic [SW-1:0]               sayac;
  logic [SW-1:0]               sayac_ns;
  logic                        push;
  logic                        pop;

  assign push = bb_buy_gecerli_g && gc_hazir_c && (durum == ALICI_AKIS) && !yonlendir_g;
  assign pop  = coz_gecerli_c && coz_hazir_g && !yonlendir_g;

  always_comb begin
    sayac_ns = sayac;
    if (yonlendir_g)       sayac_ns = '0;
    else if (push && !pop) sayac_ns = sayac + 1'b1;
    else if (pop && !push) sayac_ns = sayac - 1'b1;
  end

  buyruk_fifo #(
    .DERINLIK (DERINLIK),
    .GENISLIK (BUYRUK_BIT + BB_ADRES_BIT)
  ) u_fifo (
    .clk_g    (clk_g),
    .rst_g    (rst_g),
    .push     (push),
    .pop      (pop),
    .flush    (yonlendir_g),
    .yaz_veri ({bb_buy_g, bb_buy_ps_g}),
    .oku_veri ({coz_buyruk_c, coz_ps_c}),
    .count    (sayac)
  );

  // Ready drops one entry early so the push already in flight still fits.
  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      durum          <= ALICI_AKIS;
      gc_hazir_c     <= LOW;
      bb_buy_istek_c <= LOW;
      istek_adres_r  <= '0;
    end else begin
      gc_hazir_c <= (sayac_ns <= SW'(DERINLIK-2));
      if (yonlendir_g) begin
        istek_adres_r  <= yonlendir_adres_g;
        durum          <= ALICI_ISTEK;
        bb_buy_istek_c <= HIGH;
      end else begin
        case (durum)
          ALICI_AKIS: bb_buy_istek_c <= LOW;
          ALICI_ISTEK: begin
            if (gc_hazir_c) begin
              durum          <= ALICI_ATLA;
              bb_buy_istek_c <= LOW;
            end
          end
          ALICI_ATLA: begin
            durum          <= ALICI_AKIS;
            bb_buy_istek_c <= LOW;
          end
          default: begin
            durum          <= ALICI_AKIS;
            bb_buy_istek_c <= LOW;
          end
        endcase
      end
    end
  end

  assign bb_buy_istek_adres_c = istek_adres_r;
  assign coz_gecerli_c        = (sayac != '0);
endmodule

// File: tb/tb_buyruk_alici.sv
// tb/tb_buyruk_alici.sv - self-checking bench for buyruk_alici
module tb_buyruk_alici;
  import buyruk_alici_pkg::*;

  localparam int DERINLIK = 4;

  logic        clk_g = 1'b0;
  logic        rst_g = 1'b1;
  logic        bb_buy_gecerli_g = 1'b0;
  logic [31:0] bb_buy_g = '0;
  logic [31:0] bb_buy_ps_g = '0;
  logic        gc_hazir_c;
  logic        bb_buy_istek_c;
  logic [31:0] bb_buy_istek_adres_c;
  logic        yonlendir_g = 1'b0;
  logic [31:0] yonlendir_adres_g = '0;
  logic        coz_hazir_g = 1'b0;
  logic        coz_gecerli_c;
  logic [31:0] coz_buyruk_c;
  logic [31:0] coz_ps_c;

  buyruk_alici #(.DERINLIK(DERINLIK)) dut (
    .clk_g                (clk_g),
    .rst_g                (rst_g),
    .bb_buy_gecerli_g     (bb_buy_gecerli_g),
    .bb_buy_g             (bb_buy_g),
    .bb_buy_ps_g          (bb_buy_ps_g),
    .gc_hazir_c           (gc_hazir_c),
    .bb_buy_istek_c       (bb_buy_istek_c),
    .bb_buy_istek_adres_c (bb_buy_istek_adres_c),
    .yonlendir_g          (yonlendir_g),
    .yonlendir_adres_g    (yonlendir_adres_g),
    .coz_hazir_g          (coz_hazir_g),
    .coz_gecerli_c        (coz_gecerli_c),
    .coz_buyruk_c         (coz_buyruk_c),
    .coz_ps_c             (coz_ps_c)
  );

  always #5 clk_g = ~clk_g;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: accepted instructions in a queue, plus redirect phase
  // (0 streaming, 1 requesting, 2 skip cycle after the request was taken).
  logic [63:0] mq[$];
  bit          m_hazir;
  int          m_faz;
  logic [31:0] m_adres;
  bit          m_push;

  typedef struct {
    bit          v;
    logic [31:0] ps;
    bit          ch;
    bit          exp_gec;
    logic [31:0] exp_ps;
    bit          exp_hazir;
  } vektor_t;

  vektor_t tablo[6];

  function automatic logic [31:0] kelime(input logic [31:0] ps);
    return ps ^ 32'hC0DE_0000;
  endfunction

  task automatic kontrol(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
    n_cmp++;
    if (gercek !== beklenen) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", ad, gercek, beklenen);
    end
  endtask

  task automatic karsilastir();
    kontrol("hazir", 64'(gc_hazir_c), 64'(m_hazir));
    kontrol("istek", 64'(bb_buy_istek_c), 64'(m_faz == 1));
    kontrol("istek_adres", 64'(bb_buy_istek_adres_c), 64'(m_adres));
    kontrol("gecerli", 64'(coz_gecerli_c), 64'(mq.size() != 0));
    if (mq.size() != 0) kontrol("bas", {coz_buyruk_c, coz_ps_c}, mq[0]);
  endtask

  task automatic adim();
    bit yon, psh, pp;
    yon = yonlendir_g;
    psh = bb_buy_gecerli_g && m_hazir && (m_faz == 0) && !yon;
    pp  = (mq.size() != 0) && coz_hazir_g && !yon;
    if (yon) begin
      mq.delete();
      m_adres = yonlendir_adres_g;
      m_faz   = 1;
    end else begin
      if (psh) kontrol("tasma", 64'(mq.size() < DERINLIK), 64'd1);
      if (pp)  void'(mq.pop_front());
      if (psh) mq.push_back({bb_buy_g, bb_buy_ps_g});
      if (m_faz == 1 && m_hazir) m_faz = 2;
      else if (m_faz == 2)       m_faz = 0;
    end
    m_hazir = (mq.size() <= DERINLIK - 2);
    m_push  = psh;
    @(posedge clk_g);
    #1;
    karsilastir();
  endtask

  task automatic sur(input bit v, input logic [31:0] ps, input bit ch, input bit y, input logic [31:0] ya);
    bb_buy_gecerli_g  = v;
    bb_buy_ps_g       = ps;
    bb_buy_g          = kelime(ps);
    coz_hazir_g       = ch;
    yonlendir_g       = y;
    yonlendir_adres_g = ya;
    adim();
  endtask

  task automatic model_sifirla();
    mq.delete();
    m_hazir = 1'b0;
    m_faz   = 0;
    m_adres = '0;
    m_push  = 1'b0;
  endtask

  initial begin
    int k;
    int istek_say;
    model_sifirla();
    tablo[0] = '{v:1'b0, ps:32'h0,   ch:1'b1, exp_gec:1'b0, exp_ps:32'h0,   exp_hazir:1'b1};
    tablo[1] = '{v:1'b1, ps:32'h100, ch:1'b1, exp_gec:1'b1, exp_ps:32'h100, exp_hazir:1'b1};
    tablo[2] = '{v:1'b1, ps:32'h104, ch:1'b1, exp_gec:1'b1, exp_ps:32'h104, exp_hazir:1'b1};
    tablo[3] = '{v:1'b1, ps:32'h108, ch:1'b1, exp_gec:1'b1, exp_ps:32'h108, exp_hazir:1'b1};
    tablo[4] = '{v:1'b1, ps:32'h10C, ch:1'b1, exp_gec:1'b1, exp_ps:32'h10C, exp_hazir:1'b1};
    tablo[5] = '{v:1'b0, ps:32'h0,   ch:1'b1, exp_gec:1'b0, exp_ps:32'h0,   exp_hazir:1'b1};

    // Reset state
    rst_g = 1'b1;
    repeat (2) @(posedge clk_g);
    #1 rst_g = 1'b0;
    #1;
    karsilastir();

    // Streaming, table-driven
    for (int i = 0; i < 6; i++) begin
      sur(tablo[i].v, tablo[i].ps, tablo[i].ch, 1'b0, 32'h0);
      kontrol("tablo_gecerli", 64'(coz_gecerli_c), 64'(tablo[i].exp_gec));
      if (tablo[i].exp_gec) begin
        kontrol("tablo_ps", 64'(coz_ps_c), 64'(tablo[i].exp_ps));
        kontrol("tablo_buyruk", 64'(coz_buyruk_c), 64'(kelime(tablo[i].exp_ps)));
      end
      kontrol("tablo_hazir", 64'(gc_hazir_c), 64'(tablo[i].exp_hazir));
    end

    // Backpressure: five offered while decode stalls
    k = 0;
    for (int i = 0; i < 6; i++) begin
      sur(1'b1, 32'h120 + 32'(4 * k), 1'b0, 1'b0, 32'h0);
      if (m_push) k++;
    end
    kontrol("bp_hazir_dustu", 64'(gc_hazir_c), 64'd0);
    kontrol("bp_kabul_adet", 64'(k), 64'd3);
    for (int i = 0; i < 20; i++) begin
      if (k >= 5 && mq.size() == 0) break;
      sur(k < 5, 32'h120 + 32'(4 * k), 1'b1, 1'b0, 32'h0);
      if (m_push) k++;
    end
    kontrol("bp_hepsi_kabul", 64'(k), 64'd5);
    kontrol("bp_bos", 64'(coz_gecerli_c), 64'd0);

    // Redirect with three queued
    sur(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    sur(1'b1, 32'h104, 1'b0, 1'b0, 32'h0);
    sur(1'b1, 32'h108, 1'b0, 1'b0, 32'h0);
    istek_say = 0;
    sur(1'b1, 32'h10C, 1'b0, 1'b1, 32'h200);
    kontrol("yon_bosaldi", 64'(coz_gecerli_c), 64'd0);
    kontrol("yon_adres", 64'(bb_buy_istek_adres_c), 64'h200);
    if (bb_buy_istek_c) istek_say++;
    sur(1'b1, 32'h110, 1'b1, 1'b0, 32'h0);
    if (bb_buy_istek_c) istek_say++;
    kontrol("yon_110_dusuruldu", 64'(coz_gecerli_c), 64'd0);
    sur(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    if (bb_buy_istek_c) istek_say++;
    kontrol("yon_istek_tek", 64'(istek_say), 64'd1);
    sur(1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
    kontrol("yon_ilk_ps", 64'(coz_ps_c), 64'h200);
    sur(1'b1, 32'h204, 1'b1, 1'b0, 32'h0);
    sur(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Back-to-back redirect
    sur(1'b1, 32'h130, 1'b0, 1'b1, 32'h200);
    sur(1'b1, 32'h200, 1'b0, 1'b1, 32'h300);
    kontrol("b2b_adres", 64'(bb_buy_istek_adres_c), 64'h300);
    kontrol("b2b_istek", 64'(bb_buy_istek_c), 64'd1);
    sur(1'b1, 32'h204, 1'b0, 1'b0, 32'h0);
    kontrol("b2b_eski_yok", 64'(coz_gecerli_c), 64'd0);
    sur(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    sur(1'b1, 32'h300, 1'b1, 1'b0, 32'h0);
    kontrol("b2b_ilk_ps", 64'(coz_ps_c), 64'h300);
    sur(1'b1, 32'h304, 1'b1, 1'b0, 32'h0);
    sur(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Simultaneous push and pop at two entries
    sur(1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
    sur(1'b1, 32'h404, 1'b0, 1'b0, 32'h0);
    sur(1'b1, 32'h408, 1'b1, 1'b0, 32'h0);
    kontrol("pp_hazir", 64'(gc_hazir_c), 64'd1);
    kontrol("pp_bas", 64'(coz_ps_c), 64'h404);
    sur(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    kontrol("pp_sonraki", 64'(coz_ps_c), 64'h408);
    sur(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      sur($urandom_range(0, 3) != 0, {$urandom_range(0, 16'hFFFF), 2'b00},
          $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
          {$urandom_range(0, 16'hFFFF), 2'b00});
    end

    // Asynchronous reset in the middle of a request
    sur(1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
    sur(1'b0, 32'h0, 1'b0, 1'b1, 32'h600);
    kontrol("ar_once_istek", 64'(bb_buy_istek_c), 64'd1);
    #2 rst_g = 1'b1;
    #1;
    kontrol("ar_istek", 64'(bb_buy_istek_c), 64'd0);
    kontrol("ar_gecerli", 64'(coz_gecerli_c), 64'd0);
    kontrol("ar_hazir", 64'(gc_hazir_c), 64'd0);
    model_sifirla();
    bb_buy_gecerli_g = 1'b0;
    yonlendir_g      = 1'b0;
    coz_hazir_g      = 1'b0;
    @(posedge clk_g);
    #1 rst_g = 1'b0;
    #1;
    karsilastir();
    sur(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    kontrol("ar_sonra_hazir", 64'(gc_hazir_c), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
